// File: rtl/mem_stage.sv
// Memory-access stage: issues word loads/stores over a req/ack bus, stalls upstream
// while an access is outstanding, and holds the MEM/WB pipeline register.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  WriteReg_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUResult_o,
  output logic [4:0]  WriteReg_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int            CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;

  logic          r_regwrite;
  logic          r_memtoreg;
  logic [31:0]   r_readdata;
  logic [31:0]   r_aluresult;
  logic [4:0]    r_writereg;
  logic          r_misalign;
  logic          r_bus_err;

  logic          w_memop;
  logic          w_misaligned;
  logic          w_issue;
  logic          w_done;
  logic          w_tmo;
  logic          w_stall;

  assign w_memop      = MemToReg_i | MemWrite_i;
  assign w_misaligned = w_memop & (ALUResult_i[1:0] != 2'b00);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Ack is checked before the timeout so a same-cycle ack completes normally.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop && !w_misaligned) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == TO_VAL) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_stall = w_memop & ~w_misaligned & ~w_done & ~w_tmo;

  // ---- Bus request register: address/data/direction frozen for all of WAIT ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else if (w_issue) begin
      r_req   <= 1'b1;
      r_we    <= MemWrite_i;
      r_addr  <= ALUResult_i;
      r_wdata <= WriteData_i;
      r_cnt   <= '0;
    end else if (w_done || w_tmo) begin
      r_req   <= 1'b0;
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // ---- MEM/WB register: bubble while stalled, faults squash the write-back ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_regwrite  <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_aluresult <= '0;
      r_writereg  <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else if (w_stall) begin
      r_regwrite  <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_regwrite  <= RegWrite_i & ~w_tmo & ~w_misaligned;
      r_memtoreg  <= MemToReg_i & ~w_tmo & ~w_misaligned;
      r_aluresult <= ALUResult_i;
      r_writereg  <= WriteReg_i;
      r_misalign  <= w_misaligned;
      r_bus_err   <= w_tmo;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)               r_readdata <= '0;
    else if (w_done && !r_we) r_readdata <= mem_rdata_i;
  end

  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign stall_o     = w_stall;
  assign RegWrite_o  = r_regwrite;
  assign MemToReg_o  = r_memtoreg;
  assign ReadData_o  = r_readdata;
  assign ALUResult_o = r_aluresult;
  assign WriteReg_o  = r_writereg;
  assign misalign_o  = r_misalign;
  assign bus_err_o   = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of operations with expected retire values, a scoreboard
// queue between issue and retire, and hand-written reset sequences.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemToReg_i, MemWrite_i;
  logic [31:0] ALUResult_i, WriteData_i;
  logic [4:0]  WriteReg_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, RegWrite_o, MemToReg_o;
  logic [31:0] ReadData_o, ALUResult_o;
  logic [4:0]  WriteReg_o;
  logic        misalign_o, bus_err_o;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .MemWrite_i(MemWrite_i),
    .ALUResult_i(ALUResult_i), .WriteData_i(WriteData_i), .WriteReg_i(WriteReg_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
    .ReadData_o(ReadData_o), .ALUResult_o(ALUResult_o), .WriteReg_o(WriteReg_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        rw, mtr, mw;
    logic [31:0] alu, wd;
    logic [4:0]  wr;
    int          ack_n;     // WAIT cycle carrying the ack, 0 = never
    logic [31:0] rdata;
    bit          gap;       // idle cycle after retire to see the flags drop
    int          x_stall, x_req;
    logic        x_rw, x_mtr, x_mis, x_berr;
  } vec_t;

  vec_t        vecs[11];
  vec_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive_nop();
    RegWrite_i = 0; MemToReg_i = 0; MemWrite_i = 0;
    ALUResult_i = '0; WriteData_i = '0; WriteReg_i = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus"}, {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, '0);
    chk({tag, "_ctl"}, {RegWrite_o, MemToReg_o, misalign_o, bus_err_o, WriteReg_o}, '0);
    chk({tag, "_rdata"}, ReadData_o, '0);
    chk({tag, "_alu"}, ALUResult_o, '0);
  endtask

  // Called just after a rising edge with the stage idle; returns just after the retire edge.
  task automatic run_op(input vec_t v);
    int   wcyc = 0, stalls = 0, reqs = 0;
    bit   done = 0;
    vec_t e;
    RegWrite_i = v.rw; MemToReg_i = v.mtr; MemWrite_i = v.mw;
    ALUResult_i = v.alu; WriteData_i = v.wd; WriteReg_i = v.wr;
    sb.push_back(v);
    for (int c = 0; c < 40 && !done; c++) begin
      mem_ack_i = 0;
      mem_rdata_i = 32'hBAD0_0000 + c;
      if (mem_req_o) begin
        reqs++; wcyc++;
        chk({v.name, "_we"}, mem_we_o, v.mw);
        chk({v.name, "_addr"}, mem_addr_o, v.alu);
        chk({v.name, "_wdata"}, mem_wdata_o, v.wd);
        if (v.ack_n == wcyc) begin
          mem_ack_i = 1;
          mem_rdata_i = v.rdata;
        end
      end
      if (c > 0) chk({v.name, "_bubble"}, {RegWrite_o, MemToReg_o}, 2'b00);
      #1;
      if (stall_o) stalls++;
      else done = 1;
      @(posedge clk_i); #1;
    end
    mem_ack_i = 0;
    if (!done) chk({v.name, "_retire_bound"}, 0, 1);
    e = sb.pop_front();
    if (e.mtr && !e.x_mis && !e.x_berr) last_rd = e.rdata;
    chk({e.name, "_stall_cycles"}, stalls, e.x_stall);
    chk({e.name, "_req_cycles"}, reqs, e.x_req);
    chk({e.name, "_req_drop"}, mem_req_o, 0);
    chk({e.name, "_ctl"}, {RegWrite_o, MemToReg_o, misalign_o, bus_err_o},
        {e.x_rw, e.x_mtr, e.x_mis, e.x_berr});
    chk({e.name, "_aluout"}, ALUResult_o, e.alu);
    chk({e.name, "_wreg"}, WriteReg_o, e.wr);
    chk({e.name, "_rdata"}, ReadData_o, last_rd);
    if (v.gap) begin
      drive_nop();
      @(posedge clk_i); #1;
      chk({e.name, "_flag_pulse"}, {misalign_o, bus_err_o, RegWrite_o}, 3'b000);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    //          name       rw mtr mw alu            wd             wr ack rdata         gap st rq rw mtr mis berr
    vecs[0]  = '{"alu",     1, 0, 0, 32'h0000_1234, 32'h0,         5, 0, 32'h0,         1, 0, 0, 1, 0, 0, 0};
    vecs[1]  = '{"load",    1, 1, 0, 32'h0000_0100, 32'h0,         7, 3, 32'hDEAD_BEEF, 1, 3, 3, 1, 1, 0, 0};
    vecs[2]  = '{"store",   0, 0, 1, 32'h0000_0200, 32'hCAFE_F00D, 0, 1, 32'h0,         1, 1, 1, 0, 0, 0, 0};
    vecs[3]  = '{"misld",   1, 1, 0, 32'h0000_0103, 32'h0,         9, 0, 32'h0,         1, 0, 0, 0, 0, 1, 0};
    vecs[4]  = '{"tmo",     1, 1, 0, 32'h0000_0300, 32'h0,        10, 0, 32'h0,         1, 5, 5, 0, 0, 0, 1};
    vecs[5]  = '{"ld_ack1", 1, 1, 0, 32'h0000_0304, 32'h0,        11, 1, 32'h1111_2222, 0, 1, 1, 1, 1, 0, 0};
    vecs[6]  = '{"ld_ack5", 1, 1, 0, 32'h0000_0308, 32'h0,        12, 5, 32'h3333_4444, 1, 5, 5, 1, 1, 0, 0};
    vecs[7]  = '{"alu_max", 1, 0, 0, 32'hFFFF_FFFF, 32'h0,        31, 0, 32'h0,         1, 0, 0, 1, 0, 0, 0};
    vecs[8]  = '{"misst",   0, 0, 1, 32'h0000_0202, 32'h1234_5678, 0, 0, 32'h0,         1, 0, 0, 0, 0, 1, 0};
    vecs[9]  = '{"st_ack2", 0, 0, 1, 32'h0000_0000, 32'h0BAD_CAFE, 0, 2, 32'h0,         1, 2, 2, 0, 0, 0, 0};
    vecs[10] = '{"alu_tail",1, 0, 0, 32'h0000_ABCC, 32'h0,        17, 0, 32'h0,         1, 0, 0, 1, 0, 0, 0};

    rst_i = 1; mem_ack_i = 0; mem_rdata_i = '0;
    drive_nop();
    @(posedge clk_i); #1;
    chk_all_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 0;
    chk("reset_stall", stall_o, 0);
    @(posedge clk_i); #1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset landing in the middle of an access, followed by a stray ack.
    RegWrite_i = 1; MemToReg_i = 1; ALUResult_i = 32'h0000_0400; WriteReg_i = 3;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("mid_req_before_rst", mem_req_o, 1);
    rst_i = 1;
    @(posedge clk_i); #1;
    chk_all_zero("mid_rst");
    drive_nop();
    @(posedge clk_i); #1;
    rst_i = 0;
    mem_ack_i = 1; mem_rdata_i = 32'h5555_AAAA;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i); #1;
      chk("stray_ack_req", mem_req_o, 0);
      chk("stray_ack_ctl", {RegWrite_o, MemToReg_o, stall_o}, 3'b000);
      chk("stray_ack_rdata", ReadData_o, 32'h0);
    end
    mem_ack_i = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, sitting directly downstream of the EX/MEM pipeline register and feeding the write-back stage. It issues loads and stores to the data memory over a request/acknowledge handshake and stalls upstream stages while an access is outstanding. It also checks word alignment and aborts accesses that exceed a timeout. It contains the MEM/WB pipeline register, so its outputs go straight to the write-back mux.

## Interface
- TIMEOUT, 255: maximum number of WAIT cycles without `mem_ack_i` before an access is aborted. Legal range 1..65535. The counter width is $clog2(TIMEOUT+1).
- clk_i  in  1  clock. All state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- RegWrite_i, MemToReg_i, MemWrite_i  in  1 each  control bits from EX/MEM. MemToReg_i=1 marks a load.
- ALUResult_i  in  32  effective address, or ALU result for non-memory ops.
- WriteData_i  in  32  store data.
- WriteReg_i  in  5  destination register.
- mem_req_o  out  1  data-memory request.
- mem_we_o  out  1  1 = store, 0 = load.
- mem_addr_o, mem_wdata_o  out  32 each  address and store data, held stable while mem_req_o=1.
- mem_ack_i  in  1  access complete.
- mem_rdata_i  in  32  load data, valid while mem_ack_i=1.
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- RegWrite_o, MemToReg_o  out  1 each  MEM/WB control outputs.
- ReadData_o, ALUResult_o  out  32 each  MEM/WB data outputs.
- WriteReg_o  out  5  MEM/WB destination register.
- misalign_o, bus_err_o  out  1 each  one-cycle fault flags, aligned with the retiring instruction.

## Operation
- `memop = MemToReg_i | MemWrite_i`. MemToReg_i and MemWrite_i are never both 1; behaviour in that case is undefined.
- `misaligned = memop & (ALUResult_i[1:0] != 0)`. Only word accesses are supported.
- FSM has two states, IDLE and WAIT. Reset enters IDLE.
- IDLE, `memop` and not misaligned:
  - latch address, data and direction into mem_addr_o, mem_wdata_o, mem_we_o;
  - set mem_req_o=1, clear the counter, go to WAIT.
- IDLE, any other case: stay in IDLE.
- WAIT, mem_ack_i=1:
  - mem_req_o<=0, return to IDLE;
  - for a load, ReadData_o<=mem_rdata_i.
- WAIT, mem_ack_i=0 and counter==TIMEOUT:
  - mem_req_o<=0, return to IDLE;
  - bus_err_o<=1; RegWrite_o and MemToReg_o are forced to 0.
- WAIT, any other case: counter increments.
- An acknowledge and a timeout in the same cycle complete normally; the ack wins.
- mem_ack_i is ignored in IDLE.
- `stall_o = memop & ~misaligned & ~(state==WAIT & (mem_ack_i | counter==TIMEOUT))`. It is combinational.
- MEM/WB register, updated every cycle:
  - when stall_o=1, it loads a bubble: RegWrite_o, MemToReg_o, misalign_o and bus_err_o are 0; data fields hold their values;
  - otherwise it captures RegWrite_i, MemToReg_i, ALUResult_i and WriteReg_i;
  - ReadData_o changes only on load completion.
- Misaligned op: no request and no stall. It retires in one cycle with misalign_o=1, RegWrite_o=0, MemToReg_o=0.
- Reset, including in mid-access: state returns to IDLE and mem_req_o drops at that edge. All outputs (mem_*_o, the MEM/WB fields, the flags) are 0. Any outstanding ack is ignored.

## Timing
- Non-memory op: one cycle through the stage, zero stall.
- Memory op with the ack in the Nth WAIT cycle (N≥1):
  - stall_o is high for N cycles;
  - mem_req_o is high for N cycles, starting the cycle after the op arrives;
  - results appear on the MEM/WB outputs on the edge after the ack.
- Timeout: mem_req_o is high for TIMEOUT+1 cycles and stall_o for TIMEOUT+1 cycles. bus_err_o pulses for one cycle.
- Back-to-back memory ops: the next op sees IDLE on the cycle after completion, so there is no dead cycle beyond the mandatory issue cycle.
- mem_addr_o, mem_wdata_o and mem_we_o are registered and constant for the whole of WAIT.

## Test plan
- Reset: assert rst_i for 2 cycles while in WAIT with mem_req_o=1. Required: mem_req_o=0 and every output 0 after the first edge; an ack arriving afterwards is ignored.
- ALU op: RegWrite_i=1, ALUResult_i=0x00001234, WriteReg_i=5. Required: stall_o never high; next cycle RegWrite_o=1, ALUResult_o=0x00001234, WriteReg_o=5.
- Load: address 0x100, ack in the 3rd WAIT cycle with rdata 0xDEADBEEF. Required: stall_o high 3 cycles; mem_req_o high 3 cycles with mem_we_o=0; RegWrite_o=0 during the stall; then ReadData_o=0xDEADBEEF, MemToReg_o=1, RegWrite_o=1.
- Store: address 0x200, data 0xCAFEF00D, ack in the 1st WAIT cycle. Required: mem_we_o=1, mem_addr_o=0x200, mem_wdata_o=0xCAFEF00D; stall_o high 1 cycle; RegWrite_o=0 on retire.
- Misaligned load at 0x103. Required: mem_req_o stays 0, stall_o 0; next cycle misalign_o=1 and RegWrite_o=0 for one cycle.
- Timeout with TIMEOUT=4 and no ack:
  - required: mem_req_o high 5 cycles, then bus_err_o=1 for one cycle with RegWrite_o=0;
  - a following load with an ack in the 1st WAIT cycle completes normally;
  - repeat with the ack in the 5th WAIT cycle: it completes normally with bus_err_o=0.
